// File: rtl/adder_operand_loader.sv
// adder_operand_loader: synchronizes a pad strobe and captures an operand pair for a downstream adder
module adder_operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load_stb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [7:0]       pair_count,
  output logic             overrun,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, HAVE_A = 2'd1, PAIR_VALID = 2'd2, BAD = 2'd3} state_t;
  state_t state, state_n;
  logic sync1, sync2, dly, act, overrun_n;
  logic [WIDTH-1:0] op_a_n, op_b_n;
  logic [7:0] count_n;
  assign act = sync2 & ~dly & ena;
  assign op_valid = state == PAIR_VALID;
  assign state_dbg = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      {sync1, sync2, dly} <= 3'b000;
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      pair_count <= 8'd0;
      overrun <= 1'b0;
    end else begin
      {sync1, sync2, dly} <= {load_stb, sync1, sync2};
      state <= state_n;
      op_a <= op_a_n;
      op_b <= op_b_n;
      pair_count <= count_n;
      overrun <= overrun_n;
    end
  end
  always_comb begin
    state_n = state;
    op_a_n = op_a;
    op_b_n = op_b;
    count_n = pair_count;
    overrun_n = overrun;
    if (clear) begin
      state_n = IDLE;
      overrun_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          op_a_n = act ? data_in : op_a;
          state_n = act ? HAVE_A : IDLE;
        end
        HAVE_A: begin
          op_b_n = act ? data_in : op_b;
          state_n = act ? PAIR_VALID : HAVE_A;
        end
        PAIR_VALID: begin
          state_n = op_ready ? IDLE : PAIR_VALID;
          count_n = op_ready ? pair_count + 8'd1 : pair_count;
          overrun_n = overrun | act;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_operand_loader.sv
// tb_adder_operand_loader: vector table, directed corner sequences and random traffic against a reference model
module tb_adder_operand_loader;
  logic clk = 1'b0;
  logic rst, ena, load_stb, clear, op_ready, op_valid, overrun;
  logic [7:0] data_in, op_a, op_b, pair_count;
  logic [1:0] state_dbg;
  int checks = 0;
  int errors = 0;
  int m_n, m_pairs;
  logic [7:0] m_a, m_b;
  bit m_ovr;
  bit hist[$];
  typedef struct {
    logic [3:0] ctl;
    logic [7:0] d;
    logic rdy;
    logic [1:0] st;
    logic [7:0] a, b, cnt;
    logic ov;
  } vec_t;
  vec_t tbl[$];
  adder_operand_loader #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .load_stb(load_stb), .data_in(data_in), .clear(clear),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .pair_count(pair_count), .overrun(overrun), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic model_step();
    bit edge_seen;
    if (rst) begin
      m_n = 0;
      m_a = 8'h00;
      m_b = 8'h00;
      m_pairs = 0;
      m_ovr = 1'b0;
      hist = '{1'b0, 1'b0, 1'b0};
      return;
    end
    edge_seen = hist[1] && !hist[2] && ena;
    hist.push_front(load_stb);
    void'(hist.pop_back());
    if (clear) begin
      m_n = 0;
      m_ovr = 1'b0;
    end else if (m_n == 2) begin
      if (edge_seen) m_ovr = 1'b1;
      if (op_ready) begin
        m_n = 0;
        m_pairs = (m_pairs + 1) % 256;
      end
    end else if (edge_seen) begin
      if (m_n == 0) m_a = data_in;
      else m_b = data_in;
      m_n++;
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_model(string t);
    chk({t, " state"}, 32'(state_dbg), 32'(m_n));
    chk({t, " op_valid"}, 32'(op_valid), 32'(m_n == 2));
    chk({t, " op_a"}, 32'(op_a), 32'(m_a));
    chk({t, " op_b"}, 32'(op_b), 32'(m_b));
    chk({t, " pair_count"}, 32'(pair_count), 32'(m_pairs));
    chk({t, " overrun"}, 32'(overrun), 32'(m_ovr));
  endtask
  task automatic strobe(logic [7:0] d);
    data_in = d;
    load_stb = 1'b1;
    cyc();
    load_stb = 1'b0;
    cyc();
    cyc();
  endtask
  task automatic add(logic [3:0] ctl, logic [7:0] d, logic rdy, logic [1:0] st,
                     logic [7:0] a, logic [7:0] b, logic [7:0] cnt, logic ov);
    tbl.push_back('{ctl, d, rdy, st, a, b, cnt, ov});
  endtask
  initial begin
    hist = '{1'b0, 1'b0, 1'b0};
    {rst, clear, ena, load_stb, op_ready} = 5'b10100;
    data_in = 8'h00;
    add(4'b1010, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    add(4'b0011, 8'h3C, 1'b0, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    add(4'b0010, 8'h3C, 1'b0, 2'd0, 8'h00, 8'h00, 8'd0, 1'b0);
    add(4'b0010, 8'h3C, 1'b0, 2'd1, 8'h3C, 8'h00, 8'd0, 1'b0);
    add(4'b0011, 8'hA5, 1'b1, 2'd1, 8'h3C, 8'h00, 8'd0, 1'b0);
    add(4'b0010, 8'hA5, 1'b1, 2'd1, 8'h3C, 8'h00, 8'd0, 1'b0);
    add(4'b0010, 8'hA5, 1'b1, 2'd2, 8'h3C, 8'hA5, 8'd0, 1'b0);
    add(4'b0010, 8'hA5, 1'b1, 2'd0, 8'h3C, 8'hA5, 8'd1, 1'b0);
    add(4'b0001, 8'h77, 1'b0, 2'd0, 8'h3C, 8'hA5, 8'd1, 1'b0);
    add(4'b0000, 8'h77, 1'b0, 2'd0, 8'h3C, 8'hA5, 8'd1, 1'b0);
    add(4'b0000, 8'h77, 1'b0, 2'd0, 8'h3C, 8'hA5, 8'd1, 1'b0);
    add(4'b0010, 8'h77, 1'b0, 2'd0, 8'h3C, 8'hA5, 8'd1, 1'b0);
    add(4'b0011, 8'hC3, 1'b0, 2'd0, 8'h3C, 8'hA5, 8'd1, 1'b0);
    add(4'b0010, 8'hC3, 1'b0, 2'd0, 8'h3C, 8'hA5, 8'd1, 1'b0);
    add(4'b0010, 8'hC3, 1'b0, 2'd1, 8'hC3, 8'hA5, 8'd1, 1'b0);
    add(4'b0011, 8'hA5, 1'b0, 2'd1, 8'hC3, 8'hA5, 8'd1, 1'b0);
    add(4'b0010, 8'hA5, 1'b0, 2'd1, 8'hC3, 8'hA5, 8'd1, 1'b0);
    add(4'b0010, 8'hA5, 1'b0, 2'd2, 8'hC3, 8'hA5, 8'd1, 1'b0);
    add(4'b0011, 8'hFF, 1'b0, 2'd2, 8'hC3, 8'hA5, 8'd1, 1'b0);
    add(4'b0010, 8'hFF, 1'b0, 2'd2, 8'hC3, 8'hA5, 8'd1, 1'b0);
    add(4'b0010, 8'hFF, 1'b0, 2'd2, 8'hC3, 8'hA5, 8'd1, 1'b1);
    add(4'b0110, 8'hFF, 1'b1, 2'd0, 8'hC3, 8'hA5, 8'd1, 1'b0);
    foreach (tbl[i]) begin
      {rst, clear, ena, load_stb} = tbl[i].ctl;
      data_in = tbl[i].d;
      op_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl%0d state", i), 32'(state_dbg), 32'(tbl[i].st));
      chk($sformatf("tbl%0d op_valid", i), 32'(op_valid), 32'(tbl[i].st == 2'd2));
      chk($sformatf("tbl%0d op_a", i), 32'(op_a), 32'(tbl[i].a));
      chk($sformatf("tbl%0d op_b", i), 32'(op_b), 32'(tbl[i].b));
      chk($sformatf("tbl%0d pair_count", i), 32'(pair_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d overrun", i), 32'(overrun), 32'(tbl[i].ov));
    end
    {rst, clear, ena, load_stb, op_ready} = 5'b00100;
    cyc();
    strobe(8'h12);
    strobe(8'h34);
    chk("bp loaded", 32'(state_dbg), 32'd2);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp valid", 32'(op_valid), 32'd1);
      chk("bp op_a", 32'(op_a), 32'h12);
      chk("bp op_b", 32'(op_b), 32'h34);
    end
    op_ready = 1'b1;
    cyc();
    chk("bp release state", 32'(state_dbg), 32'd0);
    chk("bp release count", 32'(pair_count), 32'd2);
    op_ready = 1'b0;
    strobe(8'h21);
    strobe(8'h43);
    load_stb = 1'b1;
    data_in = 8'hEE;
    cyc();
    load_stb = 1'b0;
    cyc();
    op_ready = 1'b1;
    cyc();
    chk("xfer+edge state", 32'(state_dbg), 32'd0);
    chk("xfer+edge overrun", 32'(overrun), 32'd1);
    chk("xfer+edge op_a", 32'(op_a), 32'h21);
    chk_model("xfer+edge");
    op_ready = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk_model("post clear");
    strobe(8'h5A);
    chk("abort have_a", 32'(state_dbg), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort rst state", 32'(state_dbg), 32'd0);
    chk("abort rst op_a", 32'(op_a), 32'h00);
    strobe(8'h6B);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("abort clr state", 32'(state_dbg), 32'd0);
    chk("abort clr op_a", 32'(op_a), 32'h6B);
    rst = 1'b1;
    load_stb = 1'b1;
    data_in = 8'h9C;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rel edge1", 32'(state_dbg), 32'd0);
    cyc();
    chk("rel edge2", 32'(state_dbg), 32'd0);
    cyc();
    chk("rel edge3 state", 32'(state_dbg), 32'd1);
    chk("rel edge3 op_a", 32'(op_a), 32'h9C);
    for (int i = 0; i < 4; i++) cyc();
    chk("rel held one edge", 32'(state_dbg), 32'd1);
    load_stb = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    op_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      strobe(8'(i));
      strobe(8'(i + 7));
      cyc();
      if (i == 255) chk("wrap 255", 32'(pair_count), 32'd255);
    end
    chk("wrap 0", 32'(pair_count), 32'd0);
    chk_model("wrap");
    op_ready = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 255) == 0;
      clear = $urandom_range(0, 63) == 0;
      ena = $urandom_range(0, 7) != 0;
      load_stb = $urandom_range(0, 3) == 0;
      op_ready = $urandom_range(0, 2) == 0;
      data_in = 8'($urandom);
      cyc();
      chk_model("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
